// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the CPU memory responder.
package mem_bus_pkg;

    // Responder FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAccess,
        StResp,
        StRelease
    } state_e;

    // Encoding of the byte_access request flag.
    localparam logic ACCESS_WORD = 1'b0;
    localparam logic ACCESS_BYTE = 1'b1;

    // Bit offset of logical byte lane 'lane' within a 32-bit word.
    // Little-endian puts byte k at [8k+7:8k]; big-endian at [31-8k -: 8].
    function automatic logic [4:0] lane_offset(input logic [1:0] lane,
                                               input logic       little_endian);
        logic [4:0] off;
        off = {lane, 3'b000};
        if (!little_endian) begin
            off = 5'd24 - off;
        end
        return off;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM with per-byte write enables and a registered read.
module mem_array #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    // Write enabled lanes, or read the addressed word into the output register.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (|we_i) begin
                for (int k = 0; k < 4; k++) begin
                    if (we_i[k]) begin
                        mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU memory-bus responder: captures a level request, inserts wait states, performs one
// RAM access and answers with a one-cycle ready pulse, then waits for the request to drop.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        little_endian_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic        byte_access,
    output logic        mem_ready,
    output logic        mem_error
);

    import mem_bus_pkg::*;

    // Size of the decoded window in bytes.
    localparam logic [31:0] SpanBytes = 32'(64'd4 << DEPTH_LOG2);

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        byte_q;
    logic        write_q;
    logic        conflict_q;
    logic        le_q;

    logic [31:0] rdata_q;
    logic        ready_q;
    logic        error_q;

    logic        request;
    logic        capture;
    logic [32:0] diff;
    logic        access_err;
    logic [4:0]  lane_off;
    logic [31:0] read_word;

    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [31:0]           ram_sel_addr;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    assign request = memory_read || memory_write;
    assign capture = (state_q == StIdle) && request;

    // 33-bit subtraction: the borrow flags addresses below the window without wrapping.
    assign diff       = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign access_err = conflict_q
                     || diff[32]
                     || (diff[31:0] >= SpanBytes)
                     || ((byte_q == ACCESS_WORD) && (addr_q[1:0] != 2'b00));

    assign lane_off  = lane_offset(addr_q[1:0], le_q);
    assign read_word = (byte_q == ACCESS_BYTE) ? {24'h0, ram_rdata[lane_off +: 8]} : ram_rdata;

    // Next-state logic and wait-state counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (request) begin
                    state_d = (WAIT_STATES > 0) ? StWait : StAccess;
                end
            end
            StWait: begin
                if (32'(wait_cnt_q) + 32'd1 >= WAIT_STATES) begin
                    state_d    = StAccess;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StAccess:  state_d = StResp;
            StResp:    state_d = StRelease;
            StRelease: begin
                if (!memory_read && !memory_write) begin
                    state_d = StIdle;
                end
            end
            default:   state_d = StIdle;
        endcase
    end

    // RAM control: the read is issued on the way into ACCESS so data is ready during ACCESS;
    // writes commit only in ACCESS and only when the request passed the error check.
    always_comb begin
        ram_sel_addr = (state_q == StIdle) ? address : addr_q;
        ram_en       = 1'b0;
        ram_we       = 4'h0;
        ram_wdata    = (byte_q == ACCESS_BYTE) ? {4{wdata_q[7:0]}} : wdata_q;
        if (state_d == StAccess) begin
            ram_en = 1'b1;
        end
        if ((state_q == StAccess) && write_q && !access_err) begin
            ram_en = 1'b1;
            ram_we = (byte_q == ACCESS_BYTE) ? (4'b0001 << lane_off[4:3]) : 4'hF;
        end
    end

    assign ram_addr = DEPTH_LOG2'((ram_sel_addr - BASE_ADDR) >> 2);

    // State register and wait counter.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Request capture and registered response outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_q     <= ACCESS_WORD;
            write_q    <= 1'b0;
            conflict_q <= 1'b0;
            le_q       <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (capture) begin
                addr_q     <= address;
                wdata_q    <= wdata;
                byte_q     <= byte_access;
                write_q    <= memory_write;
                conflict_q <= memory_read && memory_write;
                le_q       <= little_endian_en;
            end
            ready_q <= (state_q == StAccess);
            error_q <= (state_q == StAccess) && access_err;
            if (state_q == StAccess) begin
                if (access_err) begin
                    rdata_q <= '0;
                end else if (!write_q) begin
                    rdata_q <= read_word;
                end
            end
        end
    end

    mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem_array (
        .clk_i  (clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    assign rdata     = rdata_q;
    assign mem_ready = ready_q;
    assign mem_error = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a driver issues requests and pushes the reference
// model's answer; a monitor pops and compares on every mem_ready pulse.
module tb_mem_responder;

    localparam int unsigned    DL   = 10;
    localparam int unsigned    WS   = 1;
    localparam logic [31:0]    BASE = 32'h0000_2000;
    localparam longint unsigned SPAN = 64'd4 << DL;

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic        little_endian_en = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        memory_read = 1'b0;
    logic        memory_write = 1'b0;
    logic        byte_access = 1'b0;
    logic        mem_ready;
    logic        mem_error;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
        int          raise;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [int];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pulses = 0;
    logic        prev_ready = 1'b0;

    mem_responder #(
        .DEPTH_LOG2 (DL),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS)
    ) dut (
        .clk             (clk),
        .n_reset         (n_reset),
        .little_endian_en(little_endian_en),
        .address         (address),
        .wdata           (wdata),
        .rdata           (rdata),
        .memory_read     (memory_read),
        .memory_write    (memory_write),
        .byte_access     (byte_access),
        .mem_ready       (mem_ready),
        .mem_error       (mem_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules on a word-indexed associative array.
    function automatic exp_t model(input bit rd, input bit wr, input bit byt, input bit le,
                                   input logic [31:0] addr, input logic [31:0] wd);
        exp_t            e;
        longint unsigned a;
        int              idx;
        int              sh;
        logic [31:0]     w;
        a       = 64'(addr);
        e.err   = (rd && wr) || (a < 64'(BASE)) || (a >= 64'(BASE) + SPAN)
               || (!byt && (a % 4) != 0);
        e.chk   = 1'b1;
        e.rdata = '0;
        e.raise = 0;
        if (!e.err) begin
            idx = int'((a - 64'(BASE)) / 4);
            sh  = le ? 8 * int'(a % 4) : 8 * (3 - int'(a % 4));
            if (wr) begin
                e.chk = 1'b0;
                if (byt) begin
                    w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
                    w = (w & ~(32'hFF << sh)) | (32'(wd[7:0]) << sh);
                    ref_mem[idx] = w;
                end else begin
                    ref_mem[idx] = wd;
                end
            end else if (!ref_mem.exists(idx)) begin
                e.chk = 1'b0;
            end else if (byt) begin
                e.rdata = (ref_mem[idx] >> sh) & 32'hFF;
            end else begin
                e.rdata = ref_mem[idx];
            end
        end
        return e;
    endfunction

    // rst_mode: 0 normal, 1 reset pulse during WAIT (aborted), 2 reset while mem_ready is high.
    task automatic issue(input bit rd, input bit wr, input bit byt, input bit le,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int hold, input int rst_mode);
        exp_t e;
        bit   seen;
        int   p0;
        @(negedge clk);
        if (rst_mode != 1) begin
            e       = model(rd, wr, byt, le, addr, wd);
            e.raise = cyc;
            sb.push_back(e);
        end
        p0               = pulses;
        memory_read      = rd;
        memory_write     = wr;
        byte_access      = byt;
        little_endian_en = le;
        address          = addr;
        wdata            = wd;
        if (rst_mode == 1) begin
            @(posedge clk);
            #1 n_reset = 1'b0;
            #1;
            chk("abort_ready", 32'(mem_ready), 32'd0);
            chk("abort_error", 32'(mem_error), 32'd0);
            chk("abort_rdata", rdata, 32'd0);
            memory_read  = 1'b0;
            memory_write = 1'b0;
            @(negedge clk);
            n_reset = 1'b1;
            @(negedge clk);
            return;
        end
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no mem_ready expected one for addr %h", addr);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end
        if (rst_mode == 2) begin
            #2 n_reset = 1'b0;
            #1;
            chk("resp_reset_ready", 32'(mem_ready), 32'd0);
            chk("resp_reset_rdata", rdata, 32'd0);
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) chk("held_pulses", 32'(pulses - p0), 32'd1);
        memory_read  = 1'b0;
        memory_write = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: compare every ready pulse against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                pulses++;
                chk("ready_width", 32'(prev_ready), 32'd0);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: got a pulse expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("mem_error", 32'(mem_error), 32'(e.err));
                    if (e.chk) chk("rdata", rdata, e.rdata);
                    chk("latency", 32'(cyc - e.raise), 32'(WS + 2));
                end
            end
            prev_ready = mem_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1);
    end

    initial begin
        bit          rd, wr, byt, le;
        int          r, idx, lane;
        logic [31:0] addr, wd;

        #1 n_reset = 1'b0;
        #1;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_ready", 32'(mem_ready), 32'd0);
        chk("reset_error", 32'(mem_error), 32'd0);
        repeat (3) @(negedge clk);
        n_reset = 1'b1;

        // Word, byte and endianness basics.
        issue(0, 1, 0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 0, 0);
        issue(1, 0, 0, 1, BASE + 32'h10, 32'h0, 0, 0);
        issue(1, 0, 1, 1, BASE + 32'h11, 32'h0, 0, 0);
        issue(1, 0, 1, 0, BASE + 32'h11, 32'h0, 0, 0);
        issue(0, 1, 1, 1, BASE + 32'h12, 32'hFFFF_FF55, 0, 0);
        issue(1, 0, 0, 1, BASE + 32'h10, 32'h0, 0, 0);

        // Error cases: misaligned, past the end, below base, wrap, both strobes.
        issue(1, 0, 0, 1, BASE + 32'h13, 32'h0, 0, 0);
        issue(1, 0, 0, 1, BASE + 32'd4096, 32'h0, 0, 0);
        issue(1, 0, 0, 1, BASE - 32'd4, 32'h0, 0, 0);
        issue(1, 0, 0, 1, 32'h0000_0000, 32'h0, 0, 0);
        issue(0, 1, 0, 1, 32'hFFFF_FFFC, 32'h1111_2222, 0, 0);
        issue(1, 1, 0, 1, BASE + 32'h10, 32'h0000_0000, 0, 0);
        issue(1, 0, 0, 1, BASE + 32'h10, 32'h0, 0, 0);

        // Last word of the window.
        issue(0, 1, 0, 1, BASE + 32'hFFC, 32'hA5A5_0001, 0, 0);
        issue(1, 0, 0, 1, BASE + 32'hFFC, 32'h0, 0, 0);

        // Held request: one write, one pulse.
        issue(0, 1, 0, 1, BASE + 32'h14, 32'hCAFE_F00D, 10, 0);
        issue(1, 0, 0, 1, BASE + 32'h14, 32'h0, 0, 0);

        // Reset during WAIT aborts the write; reset during RESP drops mem_ready.
        issue(0, 1, 0, 1, BASE + 32'h20, 32'h0BAD_C0DE, 0, 0);
        issue(1, 0, 0, 1, BASE + 32'h10, 32'h0, 0, 0);
        issue(0, 1, 0, 1, BASE + 32'h20, 32'h1234_5678, 0, 1);
        issue(1, 0, 0, 1, BASE + 32'h20, 32'h0, 0, 0);
        issue(1, 0, 0, 1, BASE + 32'h10, 32'h0, 0, 2);
        issue(1, 0, 0, 1, BASE + 32'h20, 32'h0, 0, 0);

        // Random traffic over a pre-written pool of words.
        for (int i = 4; i < 12; i++) begin
            issue(0, 1, 0, 1, BASE + 32'(i * 4), $urandom(), 0, 0);
        end
        for (int i = 0; i < 150; i++) begin
            r    = int'($urandom_range(0, 9));
            idx  = int'($urandom_range(4, 11));
            byt  = 1'($urandom_range(0, 1));
            le   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            rd   = !wr;
            lane = byt ? int'($urandom_range(0, 3)) : 0;
            addr = BASE + 32'(idx * 4 + lane);
            wd   = $urandom();
            if (r == 0) begin
                byt  = 1'b0;
                addr = BASE + 32'(idx * 4) + 32'($urandom_range(1, 3));
            end else if (r == 1) begin
                addr = $urandom();
            end else if (r == 2) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            issue(rd, wr, byt, le, addr, wd, 0, 0);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Bus-side responder for the CPU memory interface. It answers the CPU's address, data, memory_read and memory_write request signals with read data, a one-cycle ready pulse and an error flag, backed by an internal word-organised RAM. Wait states are programmable. It supports word and byte access with selectable endianness and a four-phase release handshake, so a held request is never serviced twice.

Parameters:
DEPTH_LOG2, 10, RAM depth in 32-bit words (2^DEPTH_LOG2 words).
BASE_ADDR, 32'h0000_0000, first byte address decoded by this responder.
WAIT_STATES, 1, extra cycles between request capture and the RAM access cycle (0..15).

Ports:
clk  input  1  system clock, rising edge.
n_reset  input  1  asynchronous active-low reset.
little_endian_en  input  1  1 = byte k of a word is data[8k+7:8k]; 0 = data[31-8k -: 8].
address  input  32  byte address from CPU.
wdata  input  32  write data from CPU (CPU data_out).
rdata  output  32  read data to CPU (CPU data_in).
memory_read  input  1  read request (level, held until mem_ready).
memory_write  input  1  write request (level, held until mem_ready).
byte_access  input  1  1 = single byte (LDRB/STRB), 0 = word.
mem_ready  output  1  one-cycle pulse: access complete, rdata/mem_error valid.
mem_error  output  1  valid with mem_ready; access rejected.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; rdata = 0, mem_ready = 0, mem_error = 0; wait counter = 0. RAM contents are not reset. A write aborted before its ACCESS cycle is never committed.
- States: IDLE, WAIT, ACCESS, RESP, RELEASE.
- IDLE:
  - If memory_read or memory_write is high, latch address, wdata, byte_access, the read/write direction and little_endian_en.
  - Go to WAIT if WAIT_STATES > 0, else go to ACCESS.
- WAIT: count WAIT_STATES cycles, then go to ACCESS. The CPU must hold its request; input changes during WAIT are ignored because latched values are used.
- ACCESS: perform the error check, then the RAM read or write (one cycle); go to RESP.
- Error conditions (any one sets mem_error and suppresses the access; rdata = 0, RAM unchanged):
  - memory_read and memory_write both high at capture;
  - address < BASE_ADDR or address >= BASE_ADDR + 4*2^DEPTH_LOG2;
  - word access with address[1:0] != 0.
- Word index = (address - BASE_ADDR) >> 2; byte lane k = address[1:0].
- Word read: rdata = stored word. Word write: all four lanes written.
- Byte read: rdata = {24'h0, selected lane}. Lane selection per little_endian_en as defined under Ports.
- Byte write: only the selected lane is written, using wdata[7:0]; the other three lanes are unchanged.
- RESP:
  - mem_ready = 1 for exactly this cycle; mem_error is valid here. rdata holds its value until the next ACCESS.
  - Go to RELEASE.
- RELEASE: stay until memory_read == 0 and memory_write == 0 in the same cycle, then go to IDLE. This guarantees one access per request.
- Latency: request seen at edge N gives mem_ready high in cycle N + WAIT_STATES + 2. The minimum back-to-back period is WAIT_STATES + 4 cycles, because the RELEASE exit cycle and the IDLE capture cycle are separate.
- mem_ready and mem_error are registered outputs; no combinational path from inputs to outputs.
- Address wrap: BASE_ADDR + offset arithmetic is 32-bit unsigned. An address below BASE_ADDR is rejected; it must not wrap into the array.
- Reset asserted in RESP: mem_ready drops immediately (asynchronous).

Decomposition:
- Package mem_bus_pkg:
  - state enum {IDLE, WAIT, ACCESS, RESP, RELEASE};
  - lane-select function (lane, little_endian) returning the bit offset;
  - the ACCESS_WORD and ACCESS_BYTE constants.
- One sub-module, mem_array: synchronous single-port RAM of 2^DEPTH_LOG2 x 32 with a 4-bit byte write enable and a registered read. The FSM and error logic stay in mem_responder.

Test Plan:
- WAIT_STATES=1, little-endian. Word write 32'hDEADBEEF to 0x10, then word read 0x10 gives rdata = 32'hDEADBEEF and mem_error = 0. mem_ready arrives exactly 3 cycles after request capture and is high for 1 cycle.
- Little-endian, after the above: byte read 0x11 gives 32'h000000BE. Set little_endian_en = 0: byte read 0x11 gives 32'h000000AD.
- Byte write 8'h55 to 0x12 (little-endian), then word read 0x10 gives 32'hDE55BEEF; the other lanes are untouched.
- Word read 0x13 gives mem_error = 1 and rdata = 0. Read at BASE_ADDR + 4096 (DEPTH_LOG2 = 10) gives mem_error = 1. memory_read and memory_write both high gives mem_error = 1 and the RAM is unchanged.
- Hold memory_write high for 10 cycles after mem_ready: exactly one write occurs and no second mem_ready pulse until the request drops and is re-raised.
- Pulse n_reset low during WAIT of a write of 32'h12345678 to 0x20: outputs are 0 immediately and a later read of 0x20 returns its prior value.
